// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_CSUM  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  localparam int          FRAME_LEN_BYTES = 4;
  localparam int          WORD_BYTES      = 4;
  localparam logic [7:0]  CSUM_GOOD       = 8'h00;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word packer shared by the length field and the data words.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic        capture,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        last,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;
  logic [1:0]  last_idx;

  assign last_idx  = capture ? 2'(WORD_BYTES - 1) : 2'(FRAME_LEN_BYTES - 1);
  assign word_next = {shift_q, byte_in};
  assign last      = byte_en && (cnt_q == last_idx);

  // word only updates on captured data words so it holds between writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= last && capture;
      if (last && capture)
        word <= word_next;
      if (clear) begin
        cnt_q <= '0;
      end else if (byte_en) begin
        shift_q <= word_next[23:0];
        cnt_q   <= cnt_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length/data/checksum frame and writes instruction memory.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             cpu_rst,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded
);

  state_t           state;
  logic [7:0]       acc;
  logic [CNT_W-1:0] len_n;
  logic [CNT_W-1:0] rx_words;
  logic [CNT_W-1:0] word_idx;
  logic             xfer;
  logic             start_ok;
  logic             pk_en;
  logic             pk_last;
  logic [31:0]      pk_next;

  assign in_ready     = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
  assign xfer         = in_valid && in_ready;
  assign start_ok     = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
  assign pk_en        = xfer && (state != ST_CSUM);
  assign words_loaded = word_idx;

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_ok),
    .byte_en    (pk_en),
    .capture    (state == ST_DATA),
    .byte_in    (in_data),
    .word_next  (pk_next),
    .last       (pk_last),
    .word       (imem_wdata),
    .word_valid (imem_we)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      len_n     <= '0;
      rx_words  <= '0;
      word_idx  <= '0;
      imem_addr <= '0;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (imem_we)
        word_idx <= word_idx + CNT_W'(1);
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state    <= ST_LEN;
            acc      <= '0;
            rx_words <= '0;
            word_idx <= '0;
            cpu_rst  <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
          end
        end
        ST_LEN: begin
          if (xfer) begin
            acc <= acc ^ in_data;
            // decide on the 4th byte itself so an oversize frame errors next cycle
            if (pk_last) begin
              len_n <= CNT_W'(pk_next);
              if (pk_next > 32'(DEPTH)) begin
                state <= ST_ERROR;
                error <= 1'b1;
              end else if (pk_next == 32'd0) begin
                state <= ST_CSUM;
              end else begin
                state <= ST_DATA;
              end
            end
          end
        end
        ST_DATA: begin
          if (xfer) begin
            acc <= acc ^ in_data;
            if (pk_last) begin
              imem_addr <= 32'(rx_words) << 2;
              rx_words  <= rx_words + CNT_W'(1);
              if (rx_words + CNT_W'(1) == len_n)
                state <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (xfer) begin
            if ((acc ^ in_data) == CSUM_GOOD) begin
              state   <= ST_DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state <= ST_ERROR;
              error <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames, flow control, reset and start handling.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;
  logic [31:0] words_loaded;

  int          n_cmp;
  int          n_bad;
  int          n_wr;
  logic [31:0] wr_addr [0:299];
  logic [31:0] wr_data [0:299];
  logic [7:0]  frm [$];

  imem_loader #(.DEPTH(256), .CNT_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_rst      (cpu_rst),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we && n_wr < 300) begin
      wr_addr[n_wr] = imem_addr;
      wr_data[n_wr] = imem_wdata;
      n_wr++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_wait: got in_ready=0 for %0d cycles expected 1", t);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'hxx;
  endtask

  task automatic send_frame(input int gap);
    foreach (frm[i]) send(frm[i], gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_s1(input logic [7:0] csum);
    frm = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
            8'h00, 8'h00, 8'h00, 8'h00, csum};
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({pfx, "_we"},       32'(imem_we),  32'd0);
    chk({pfx, "_addr"},     imem_addr,     32'd0);
    chk({pfx, "_wdata"},    imem_wdata,    32'd0);
    chk({pfx, "_cpu_rst"},  32'(cpu_rst),  32'd1);
    chk({pfx, "_done"},     32'(done),     32'd0);
    chk({pfx, "_error"},    32'(error),    32'd0);
    chk({pfx, "_words"},    words_loaded,  32'd0);
  endtask

  task automatic chk_s1_writes(input string pfx);
    chk({pfx, "_nwr"},   32'(n_wr),  32'd2);
    chk({pfx, "_addr0"}, wr_addr[0], 32'h0000_0000);
    chk({pfx, "_data0"}, wr_data[0], 32'h2008_0005);
    chk({pfx, "_addr1"}, wr_addr[1], 32'h0000_0004);
    chk({pfx, "_data1"}, wr_data[1], 32'h0000_0000);
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  x;
    n_cmp = 0; n_bad = 0; n_wr = 0;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // normal load at full rate
    pulse_start();
    load_s1(8'h2F);
    send_frame(0);
    repeat (2) @(negedge clk);
    chk_s1_writes("s1");
    chk("s1_done",    32'(done),    32'd1);
    chk("s1_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("s1_words",   words_loaded, 32'd2);
    chk("s1_error",   32'(error),   32'd0);
    chk("s1_ready",   32'(in_ready), 32'd0);

    // bad checksum
    n_wr = 0;
    pulse_start();
    load_s1(8'h2E);
    send_frame(0);
    repeat (2) @(negedge clk);
    chk_s1_writes("s2");
    chk("s2_error",   32'(error),   32'd1);
    chk("s2_done",    32'(done),    32'd0);
    chk("s2_cpu_rst", 32'(cpu_rst), 32'd1);

    // empty frame
    n_wr = 0;
    pulse_start();
    frm = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(0);
    repeat (2) @(negedge clk);
    chk("s3e_nwr",   32'(n_wr),    32'd0);
    chk("s3e_done",  32'(done),    32'd1);
    chk("s3e_words", words_loaded, 32'd0);

    // oversize frame: 257 words
    pulse_start();
    frm = '{8'h00, 8'h00, 8'h01, 8'h01};
    send_frame(0);
    chk("s3o_error", 32'(error),    32'd1);
    chk("s3o_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("s3o_nwr",   32'(n_wr),     32'd0);
    chk("s3o_done",  32'(done),     32'd0);

    // exactly DEPTH words is accepted
    n_wr = 0;
    pulse_start();
    frm = '{8'h00, 8'h00, 8'h01, 8'h00};
    x = 8'h01;
    for (int i = 0; i < 256; i++) begin
      w = 32'(i) * 32'h0101_0101 ^ 32'h5A00_00C3;
      frm.push_back(w[31:24]); frm.push_back(w[23:16]);
      frm.push_back(w[15:8]);  frm.push_back(w[7:0]);
      x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    end
    frm.push_back(x);
    send_frame(0);
    repeat (2) @(negedge clk);
    chk("dep_nwr",   32'(n_wr),     32'd256);
    chk("dep_addr",  wr_addr[255],  32'h0000_03FC);
    chk("dep_data",  wr_data[255],  32'hFFFF_FFFF ^ 32'h5A00_00C3);
    chk("dep_data1", wr_data[1],    32'h0101_0101 ^ 32'h5A00_00C3);
    chk("dep_done",  32'(done),     32'd1);
    chk("dep_words", words_loaded,  32'd256);

    // flow control: 3 idle cycles between bytes
    n_wr = 0;
    pulse_start();
    load_s1(8'h2F);
    send_frame(3);
    repeat (2) @(negedge clk);
    chk_s1_writes("s4");
    chk("s4_done", 32'(done), 32'd1);

    // reset in the middle of a load
    n_wr = 0;
    pulse_start();
    load_s1(8'h2F);
    for (int i = 0; i < 6; i++) send(frm[i], 0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("s5");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("s5_nwr", 32'(n_wr), 32'd0);
    pulse_start();
    send_frame(0);
    repeat (2) @(negedge clk);
    chk_s1_writes("s5b");
    chk("s5b_done", 32'(done), 32'd1);

    // start during DATA is ignored
    n_wr = 0;
    pulse_start();
    for (int i = 0; i < 7; i++) send(frm[i], 0);
    pulse_start();
    for (int i = 7; i < 13; i++) send(frm[i], 0);
    repeat (2) @(negedge clk);
    chk_s1_writes("s6");
    chk("s6_done", 32'(done), 32'd1);

    // start from DONE restarts with cpu held in reset
    pulse_start();
    chk("s6r_cpu_rst", 32'(cpu_rst),  32'd1);
    chk("s6r_ready",   32'(in_ready), 32'd1);
    chk("s6r_done",    32'(done),     32'd0);
    chk("s6r_words",   words_loaded,  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for instruction memory; the instruction fetch path only reads it.
- Receives a framed byte stream over a valid/ready interface and assembles big-endian 32-bit words.
- Writes the words to instruction memory at consecutive word addresses starting at byte address 0.
- Holds the CPU in reset until a complete frame with a correct checksum has been loaded.

Parameters:
DEPTH, 256, instruction memory capacity in 32-bit words; a frame with more words than this is rejected
CNT_W, 32, width of the word-count field and internal counters

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins a load when idle, done or error
in_data  input  8  stream byte
in_valid  input  1  in_data is valid
in_ready  output  1  loader accepts a byte this cycle
imem_we  output  1  instruction memory write enable, one-cycle pulse
imem_addr  output  32  byte address, always word-aligned (word_index<<2)
imem_wdata  output  32  assembled instruction word
cpu_rst  output  1  active-high reset to the CPU program counter
done  output  1  load completed, checksum good
error  output  1  load aborted (oversize or bad checksum)
words_loaded  output  CNT_W  number of words written in the current or last load

Behaviour:
- Frame format: 4-byte word count N (MSB first), then N words of 4 bytes each (MSB first), then 1 checksum byte. The checksum byte is the XOR of all preceding frame bytes, so the XOR of the whole frame is 0x00.
- Byte transfer: a byte transfers when in_valid && in_ready. in_ready is high only in LEN, DATA and CSUM. in_data is ignored when no transfer occurs.
- States: IDLE, LEN, DATA, CSUM, DONE, ERROR.
  - IDLE: start -> LEN; clears the byte counter, word index, checksum accumulator, done, error and words_loaded.
  - LEN: 4 transfers latch N.
    - N > DEPTH -> ERROR.
    - N == 0 -> CSUM.
    - Otherwise -> DATA.
  - DATA: each 4th transfer completes a word.
    - On the following cycle: imem_we=1, imem_wdata=the word, imem_addr=word_index*4. word_index and words_loaded increment on that cycle.
    - After the Nth word's 4th byte -> CSUM. The final imem_we pulse still issues on the next cycle.
  - CSUM: 1 transfer.
    - Accumulator XOR byte == 0x00 -> DONE.
    - Otherwise -> ERROR.
  - DONE: done=1, cpu_rst=0, in_ready=0.
  - ERROR: error=1, cpu_rst=1, in_ready=0.
- start handling: start in DONE or ERROR behaves as from IDLE; cpu_rst reasserts the next cycle. start in LEN, DATA or CSUM is ignored.
- cpu_rst is 1 in every state except DONE.
- Back-to-back transfers at full rate (one byte per cycle) must be sustained. A byte accepted in the same cycle as an imem_we pulse is accumulated without loss.
- in_valid gaps of any length have no effect other than delay.
- Reset values: state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, done=0, error=0, words_loaded=0.
- rst_n asserted mid-load: immediate return to IDLE; any pending imem_we is cancelled; the partial word is discarded.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- Endianness: the first byte of a word lands in bits [31:24].

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE..ERROR)
  - FRAME_LEN_BYTES=4
  - WORD_BYTES=4
  - checksum-good constant 8'h00
- One sub-module, byte_packer:
  - 4-byte shift register plus 2-bit byte counter.
  - Outputs word and word_valid, asserted one cycle after the 4th byte.
  - Reused for both the length field and the data words.

Test Plan:
1. Normal load. Stream 00 00 00 02 | 20 08 00 05 | 00 00 00 00 | 2F.
   - imem_we at addr 0x0 data 0x20080005, then addr 0x4 data 0x00000000.
   - Final state: done=1, cpu_rst=0, words_loaded=2, error=0.
2. Bad checksum. Same stream with last byte 2E.
   - Both writes occur.
   - Final state: error=1, done=0, cpu_rst=1.
3. Empty and oversize frames.
   - Empty: 00 00 00 00 | 00 -> no imem_we, done=1, words_loaded=0.
   - Oversize: 00 00 01 01 -> error=1 the cycle after the 4th byte, in_ready=0, no imem_we.
4. Flow control. Scenario 1 with in_valid low for 3 cycles between every byte, plus in_valid=1 throughout a separate full-rate run.
   - Identical writes to scenario 1; done=1 in both cases.
5. Reset mid-load. Assert rst_n=0 after 6 bytes of scenario 1.
   - All outputs return to reset values; no further imem_we.
   - A subsequent start plus the full scenario-1 stream produces done=1.
6. Start handling.
   - start pulsed during DATA is ignored; the load completes normally.
   - start pulsed in DONE gives cpu_rst=1 and in_ready=1 the next cycle, with done=0 and words_loaded=0.
